// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet transmitter.
// Holds the tx FSM state encoding, the header/length constants, and the
// small header-pack and byte-parity helpers used by router_pkt_tx.
package router_pkg;

  localparam int         MAX_LEN      = 63;
  localparam logic [1:0] DEST_INVALID = 2'd3;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_HDR,
    TX_PAYLD,
    TX_PAR,
    TX_GAP
  } tx_state_e;

  // Router header byte: length in [7:2], destination in [1:0].
  function automatic logic [7:0] hdr_pack(input logic [5:0] len, input logic [1:0] dest);
    return {len, dest};
  endfunction

  // Running parity accumulation over one more byte.
  function automatic logic [7:0] byte_parity(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store for one packet: synchronous write, combinational read.
// Latency: write visible on the read port the cycle after the write edge.
// No flow control of its own; the owner decides when to write and what to read.
// Ports: clk; wr_en/wr_addr/wr_data write side; rd_addr -> rd_data read side.
module router_tx_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Store-and-forward packet source for the router input: loads a whole payload,
// then sends header, payload and parity back to back with no internal gaps.
// Latency: header registered on the edge accepting the last payload byte; a
// packet occupies len+2 cycles on data_out when busy stays low.
// Backpressure: busy high holds data_out/pkt_valid unchanged indefinitely;
// cmd_ready only in IDLE, pl_ready only in LOAD.
// Ports: clk, resetn (sync, active-high); cmd_valid/cmd_ready/cmd_dest/cmd_len
// command; pl_data/pl_valid/pl_ready payload; busy in; data_out/pkt_valid to
// router; pkt_done and cmd_err status pulses.
// Optional ROUTER_TX_ERR_INJECT_EN adds inj_perr, which flips parity bit 0 of
// the packet whose command it accompanies.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int IPG     = 2,
  parameter int MAX_LEN = 63
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_dest,
  input  logic [5:0] cmd_len,
`ifdef ROUTER_TX_ERR_INJECT_EN
  input  logic       inj_perr,
`endif
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       pkt_done,
  output logic       cmd_err
);

  localparam logic [3:0] GAP_LAST = (IPG > 0) ? 4'(IPG - 1) : 4'd0;

  tx_state_e  state_q, state_d;
  logic [7:0] hdr_q, hdr_d;
  logic [7:0] parity_q, parity_d;
  logic [5:0] wcnt_q, wcnt_d;
  logic [5:0] rcnt_q, rcnt_d;
  logic [3:0] gcnt_q, gcnt_d;
  logic [7:0] data_out_q, data_out_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic       pkt_done_q, pkt_done_d;
  logic       cmd_err_q, cmd_err_d;
`ifdef ROUTER_TX_ERR_INJECT_EN
  logic       inj_q, inj_d;
`endif

  logic [5:0] pkt_len;
  logic [7:0] par_byte;
  logic       buf_wr_en;
  logic [5:0] buf_rd_addr;
  logic [7:0] buf_rd_data;

  assign pkt_len = hdr_q[7:2];

`ifdef ROUTER_TX_ERR_INJECT_EN
  assign par_byte = parity_q ^ {7'd0, inj_q};
`else
  assign par_byte = parity_q;
`endif

  assign buf_wr_en = (state_q == TX_LOAD) && pl_valid;
  // Address the byte that will be registered onto data_out at the next
  // consume edge, so payload follows the header without a bubble.
  assign buf_rd_addr = (state_q == TX_PAYLD) ? rcnt_q : 6'd0;

  router_tx_buf #(
    .DEPTH (MAX_LEN + 1),
    .AW    (6)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (wcnt_q),
    .wr_data (pl_data),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd_data)
  );

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    parity_d    = parity_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    gcnt_d      = gcnt_q;
    data_out_d  = data_out_q;
    pkt_valid_d = pkt_valid_q;
    pkt_done_d  = 1'b0;
    cmd_err_d   = 1'b0;
`ifdef ROUTER_TX_ERR_INJECT_EN
    inj_d       = inj_q;
`endif

    case (state_q)
      TX_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == 6'd0 || cmd_dest == DEST_INVALID) begin
            cmd_err_d = 1'b1;
          end else begin
            hdr_d    = hdr_pack(cmd_len, cmd_dest);
            parity_d = hdr_pack(cmd_len, cmd_dest);
            wcnt_d   = 6'd0;
`ifdef ROUTER_TX_ERR_INJECT_EN
            inj_d    = inj_perr;
`endif
            state_d  = TX_LOAD;
          end
        end
      end

      TX_LOAD: begin
        if (pl_valid) begin
          parity_d = byte_parity(parity_q, pl_data);
          wcnt_d   = wcnt_q + 6'd1;
          if (wcnt_q == pkt_len - 6'd1) begin
            data_out_d  = hdr_q;
            pkt_valid_d = 1'b1;
            state_d     = TX_HDR;
          end
        end
      end

      TX_HDR: begin
        if (!busy) begin
          data_out_d = buf_rd_data;
          rcnt_d     = 6'd1;
          state_d    = TX_PAYLD;
        end
      end

      TX_PAYLD: begin
        if (!busy) begin
          if (rcnt_q < pkt_len) begin
            data_out_d = buf_rd_data;
            rcnt_d     = rcnt_q + 6'd1;
          end else begin
            // Parity travels with pkt_valid low; that is how the router
            // recognises the end of the packet.
            data_out_d  = par_byte;
            pkt_valid_d = 1'b0;
            state_d     = TX_PAR;
          end
        end
      end

      TX_PAR: begin
        if (!busy) begin
          data_out_d = 8'd0;
          pkt_done_d = 1'b1;
          gcnt_d     = 4'd0;
          state_d    = (IPG == 0) ? TX_IDLE : TX_GAP;
        end
      end

      TX_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = TX_IDLE;
        end else begin
          gcnt_d = gcnt_q + 4'd1;
        end
      end

      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= TX_IDLE;
      hdr_q       <= 8'd0;
      parity_q    <= 8'd0;
      wcnt_q      <= 6'd0;
      rcnt_q      <= 6'd0;
      gcnt_q      <= 4'd0;
      data_out_q  <= 8'd0;
      pkt_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
`ifdef ROUTER_TX_ERR_INJECT_EN
      inj_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      parity_q    <= parity_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      gcnt_q      <= gcnt_d;
      data_out_q  <= data_out_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_done_q  <= pkt_done_d;
      cmd_err_q   <= cmd_err_d;
`ifdef ROUTER_TX_ERR_INJECT_EN
      inj_q       <= inj_d;
`endif
    end
  end

  assign cmd_ready = (state_q == TX_IDLE);
  assign pl_ready  = (state_q == TX_LOAD);
  assign data_out  = data_out_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_done  = pkt_done_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: per-cycle vectors of inputs and the
// expected registered/combinational outputs after the following clock edge.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       resetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_dest;
  logic [5:0] cmd_len;
`ifdef ROUTER_TX_ERR_INJECT_EN
  logic       inj_perr;
`endif
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       pkt_done;
  logic       cmd_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  router_pkt_tx #(.IPG(2), .MAX_LEN(63)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dest  (cmd_dest),
    .cmd_len   (cmd_len),
`ifdef ROUTER_TX_ERR_INJECT_EN
    .inj_perr  (inj_perr),
`endif
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .busy      (busy),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .pkt_done  (pkt_done),
    .cmd_err   (cmd_err)
  );

  typedef struct {
    logic       rst;
    logic       cv;
    logic [1:0] cd;
    logic [5:0] cl;
    logic       plv;
    logic [7:0] pd;
    logic       bz;
    logic [7:0] e_dat;
    logic       e_pv;
    logic       e_crdy;
    logic       e_prdy;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic rst, input logic cv, input logic [1:0] cd,
                              input logic [5:0] cl, input logic plv, input logic [7:0] pd,
                              input logic bz, input logic [7:0] e_dat, input logic e_pv,
                              input logic e_crdy, input logic e_prdy, input logic e_done,
                              input logic e_err);
    vec_t v;
    v.rst = rst; v.cv = cv; v.cd = cd; v.cl = cl; v.plv = plv; v.pd = pd; v.bz = bz;
    v.e_dat = e_dat; v.e_pv = e_pv; v.e_crdy = e_crdy; v.e_prdy = e_prdy;
    v.e_done = e_done; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    resetn    = v.rst;
    cmd_valid = v.cv;
    cmd_dest  = v.cd;
    cmd_len   = v.cl;
    pl_valid  = v.plv;
    pl_data   = v.pd;
    busy      = v.bz;
    @(posedge clk);
    #1;
    chk({tag, ".data_out"},  data_out,         v.e_dat);
    chk({tag, ".pkt_valid"}, {7'd0, pkt_valid}, {7'd0, v.e_pv});
    chk({tag, ".cmd_ready"}, {7'd0, cmd_ready}, {7'd0, v.e_crdy});
    chk({tag, ".pl_ready"},  {7'd0, pl_ready},  {7'd0, v.e_prdy});
    chk({tag, ".pkt_done"},  {7'd0, pkt_done},  {7'd0, v.e_done});
    chk({tag, ".cmd_err"},   {7'd0, cmd_err},   {7'd0, v.e_err});
  endtask

  initial begin
    // XOR of 0x00..0x3E is 0x3F; with header 0xFE the parity is 0xC1.
    logic [7:0] max_par;
    max_par = 8'hC1;
`ifdef ROUTER_TX_ERR_INJECT_EN
    inj_perr = 1'b0;
`endif

    // Reset: two cycles asserted, garbage on inputs.
    step("rst0", mk(1,1,1,3,1,8'h99,1, 8'h00,0,1,0,0,0));
    step("rst1", mk(1,1,1,3,1,8'h99,1, 8'h00,0,1,0,0,0));

    // Basic packet: dest 1, len 3, A5 3C FF -> 0D A5 3C FF, parity 6B.
    vecs.push_back(mk(0,1,1,3,0,8'h00,1, 8'h00,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,8'hA5,1, 8'h00,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,8'h3C,0, 8'h00,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,8'hFF,0, 8'h0D,1,0,0,0,0));
    vecs.push_back(mk(0,1,3,0,1,8'h77,0, 8'hA5,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,8'h88,0, 8'h3C,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'hFF,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h6B,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h00,0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,1, 8'h00,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,1, 8'h00,0,1,0,0,0));

    // Stall: busy two cycles while 3C is presented, one cycle on parity.
    vecs.push_back(mk(0,1,1,3,0,8'h00,0, 8'h00,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,8'hA5,0, 8'h00,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,8'h3C,0, 8'h00,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,8'hFF,0, 8'h0D,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'hA5,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h3C,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,1, 8'h3C,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,1, 8'h3C,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'hFF,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h6B,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,1, 8'h6B,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h00,0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h00,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h00,0,1,0,0,0));

    // Illegal commands: len 0, then dest 3; payload strobes ignored.
    vecs.push_back(mk(0,1,1,0,1,8'hAA,0, 8'h00,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,8'hAA,0, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,1,3,5,1,8'hAA,0, 8'h00,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h00,0,1,0,0,0));

    // Reset in PAYLD after two payload bytes presented.
    vecs.push_back(mk(0,1,1,3,0,8'h00,0, 8'h00,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,8'hA5,0, 8'h00,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,8'h3C,0, 8'h00,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,8'hFF,0, 8'h0D,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'hA5,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h3C,1,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,8'h00,1, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h00,0,1,0,0,0));

    // Recovery, shortest packet: dest 0, len 1, 55 -> 04 55, parity 51.
    vecs.push_back(mk(0,1,0,1,0,8'h00,0, 8'h00,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,8'h55,0, 8'h04,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h55,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h51,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h00,0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h00,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00,0, 8'h00,0,1,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Max length (dest 2, len 63, payload 00..3E), then a second command
    // held high throughout so it is taken as soon as the block is idle.
    step("max.cmd", mk(0,1,2,63,0,8'h00,0, 8'h00,0,0,1,0,0));
    for (int i = 0; i < 63; i++) begin
      step($sformatf("max.ld%0d", i),
           mk(0,0,0,0,1,8'(i),0, (i == 62) ? 8'hFE : 8'h00, (i == 62),
              0, (i != 62), 0, 0));
    end
    for (int i = 0; i < 63; i++) begin
      step($sformatf("max.pl%0d", i), mk(0,1,0,2,0,8'h00,0, 8'(i),1,0,0,0,0));
    end
    step("max.par",  mk(0,1,0,2,0,8'h00,0, max_par,0,0,0,0,0));
    step("max.done", mk(0,1,0,2,0,8'h00,0, 8'h00,0,0,0,1,0));
    step("max.gap",  mk(0,1,0,2,0,8'h00,0, 8'h00,0,0,0,0,0));
    step("max.idle", mk(0,1,0,2,0,8'h00,0, 8'h00,0,1,0,0,0));
    // Second packet: dest 0, len 2, 11 22 -> 08 11 22, parity 3B.
    step("p2.cmd",   mk(0,1,0,2,0,8'h00,0, 8'h00,0,0,1,0,0));
    step("p2.ld0",   mk(0,0,0,0,1,8'h11,0, 8'h00,0,0,1,0,0));
    step("p2.ld1",   mk(0,0,0,0,1,8'h22,0, 8'h08,1,0,0,0,0));
    step("p2.hstl",  mk(0,0,0,0,0,8'h00,1, 8'h08,1,0,0,0,0));
    step("p2.b0",    mk(0,0,0,0,0,8'h00,0, 8'h11,1,0,0,0,0));
    step("p2.b1",    mk(0,0,0,0,0,8'h00,0, 8'h22,1,0,0,0,0));
    step("p2.par",   mk(0,0,0,0,0,8'h00,0, 8'h3B,0,0,0,0,0));
    step("p2.done",  mk(0,0,0,0,0,8'h00,0, 8'h00,0,0,0,1,0));
    step("p2.gap",   mk(0,0,0,0,0,8'h00,0, 8'h00,0,0,0,0,0));
    step("p2.idle",  mk(0,0,0,0,0,8'h00,0, 8'h00,0,1,0,0,0));

`ifdef ROUTER_TX_ERR_INJECT_EN
    // Injected parity error on the basic packet: 6B becomes 6A.
    inj_perr = 1'b1;
    step("inj.cmd",  mk(0,1,1,3,0,8'h00,0, 8'h00,0,0,1,0,0));
    inj_perr = 1'b0;
    step("inj.ld0",  mk(0,0,0,0,1,8'hA5,0, 8'h00,0,0,1,0,0));
    step("inj.ld1",  mk(0,0,0,0,1,8'h3C,0, 8'h00,0,0,1,0,0));
    step("inj.ld2",  mk(0,0,0,0,1,8'hFF,0, 8'h0D,1,0,0,0,0));
    step("inj.b0",   mk(0,0,0,0,0,8'h00,0, 8'hA5,1,0,0,0,0));
    step("inj.b1",   mk(0,0,0,0,0,8'h00,0, 8'h3C,1,0,0,0,0));
    step("inj.b2",   mk(0,0,0,0,0,8'h00,0, 8'hFF,1,0,0,0,0));
    step("inj.par",  mk(0,0,0,0,0,8'h00,0, 8'h6A,0,0,0,0,0));
    step("inj.done", mk(0,0,0,0,0,8'h00,0, 8'h00,0,0,0,1,0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet source for the 1x3 router's input port. It accepts a command (destination, length) and the payload bytes from a host, and stores the whole payload.
- It then emits one router packet on data_out/pkt_valid: header, payload, then parity. It honours the router's busy flow-control signal.
- It is store-and-forward because the router input cannot tolerate a gap inside a packet.
- It sits in the testbench/host-side subsystem and drives the router's data_in/pkt_valid and samples its busy.

Parameters:
- IPG, 2, idle cycles inserted after the parity byte is consumed, before the next header. Range 0..15.
- MAX_LEN, 63, maximum payload length. This is the 6-bit header length field.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  synchronous, active-high reset: asserted = 1, sampled on the rising edge of clk.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_dest  in  2  destination FIFO 0..2; 3 is illegal.
- cmd_len  in  6  payload byte count 1..63; 0 is illegal.
- pl_data  in  8  payload byte.
- pl_valid  in  1  payload byte valid.
- pl_ready  out  1  block accepting payload.
- busy  in  1  router busy; the current byte is not consumed while high.
- data_out  out  8  byte to the router's data_in.
- pkt_valid  out  1  high for the header and payload bytes, low for the parity byte.
- pkt_done  out  1  one-cycle pulse when the parity byte is consumed.
- cmd_err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset values: state IDLE; data_out = 0, pkt_valid = 0, pkt_done = 0, cmd_err = 0, pl_ready = 0. All counters and parity are 0. cmd_ready = 1 from the first cycle after reset.
- Reset mid-packet aborts: pkt_valid = 0 at the next edge and buffered payload is discarded.
- States: IDLE, LOAD, HDR, PAYLD, PAR, GAP.
- Combinational outputs: cmd_ready = (state == IDLE); pl_ready = (state == LOAD).
- IDLE:
  - cmd_valid with cmd_len == 0 or cmd_dest == 3: cmd_err pulses next cycle, state stays IDLE.
  - Any other cmd_valid: latch hdr = {cmd_len, cmd_dest}, parity = hdr, wcnt = 0; go to LOAD.
- LOAD: each pl_valid && pl_ready writes buf[wcnt], parity ^= pl_data, wcnt++. The edge that accepts byte len-1 moves to HDR. On that edge data_out = hdr and pkt_valid = 1 are registered.
- Consumption rule: a byte is consumed on a rising edge where busy == 0. While busy == 1, data_out and pkt_valid hold unchanged, with no limit on duration.
- HDR: on consume, data_out = buf[0], rcnt = 1, go to PAYLD.
- PAYLD:
  - On consume with rcnt < len: data_out = buf[rcnt], rcnt++.
  - On consume with rcnt == len: data_out = parity, pkt_valid = 0, go to PAR.
- PAR: on consume, data_out = 0, pkt_done pulses, gcnt = 0; go to GAP (or to IDLE when IPG == 0).
- GAP: hold IPG cycles, then go to IDLE.
- Latency: the header appears 1 cycle after the last payload byte is accepted. Packet duration with no busy stalls is len + 2 cycles.
- busy is ignored in IDLE, LOAD and GAP.
- pl_valid outside LOAD is ignored; no write occurs.
- Parity = XOR of the header and all payload bytes, 8 bits.
- Buffer read address is next-state driven so data_out is registered with no bubble.

Optional Feature:
- Macro: ROUTER_TX_ERR_INJECT_EN.
- Defined: adds input inj_perr (1 bit), sampled with an accepted command. If it is 1, the parity byte emitted for that packet has bit 0 inverted, to exercise the router's err output.
- Undefined: port absent; parity is always correct.

Decomposition:
- Package router_pkg:
  - tx state enum.
  - MAX_LEN = 63 and DEST_INVALID = 2'd3 constants.
  - Header pack function {len, dest}.
  - Byte-parity XOR helper.
- Sub-module router_tx_buf: 64x8 simple dual-port buffer with synchronous write and combinational read, addressed by wcnt/rcnt.
- The FSM, counters and parity stay in router_pkt_tx.

Test Plan:
- Basic packet: dest = 1, len = 3, payload A5, 3C, FF, busy = 0 → data_out sequence 0D, A5, 3C, FF (pkt_valid = 1), then 6B (pkt_valid = 0). pkt_done pulses, then 2 idle cycles before cmd_ready = 1.
- Stall: same packet with busy high for 2 cycles while 3C is presented → 3C held for 3 cycles. No byte is skipped or duplicated; parity is still 6B.
- Illegal commands: cmd_len = 0, then cmd_dest = 3 → cmd_err pulses once for each. pkt_valid is never asserted and pl_ready stays 0.
- Max length, back-to-back:
  - Packet 1: dest = 2, len = 63, payload 00..3E. Expect header FE, then 63 bytes.
  - Packet 2: issued immediately. Its header appears only after the IPG and the reload of its payload.
- Reset in PAYLD after 2 payload bytes → pkt_valid = 0 and data_out = 0 at the next edge; cmd_ready = 1 after reset.
- With ROUTER_TX_ERR_INJECT_EN, inj_perr = 1 on the basic packet → parity byte is 6A.
